// File: rtl/seq_frame_tx_if.sv
// Link bundle for the serial frame transmitter.
// The parallel word handshake and the serial output travel together.
// The master side is the word producer/link observer. The slave side is the transmitter.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              din_vld;
  logic [DATA_W-1:0] din;
  logic              din_rdy;
  logic              dout;
  logic              dout_vld;
  logic              busy;

  modport master (
    output din_vld,
    output din,
    input  din_rdy,
    input  dout,
    input  dout_vld,
    input  busy
  );

  modport slave (
    input  din_vld,
    input  din,
    output din_rdy,
    output dout,
    output dout_vld,
    output busy
  );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter.
// A frame is the header pattern followed by the payload word, sent MSB-first,
// and then an idle gap. The header and the payload share a single shift
// register, so HDR and DATA both shift out the register MSB. The counter only
// marks where each state ends.
module seq_frame_tx #(
  parameter int               DATA_W  = 8,
  parameter int               HDR_W   = 4,
  parameter logic [HDR_W-1:0] HDR_PAT = 4'b1011,
  parameter int               GAP_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_frame_tx_if.slave       link
);

  localparam int MAX_HD  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int MAX_ALL = (MAX_HD > GAP_CYC) ? MAX_HD : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int FRM_W   = HDR_W + DATA_W;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRM_W-1:0]   frame_q, frame_d;
  logic               dout_q, dout_d;
  logic               doutVld_q, doutVld_d;

  // Next-state logic. The outputs are computed one cycle ahead so that the registered dout is the bit for the coming cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    dout_d    = 1'b0;
    doutVld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (link.din_vld) begin
          state_d   = HDR;
          cnt_d     = '0;
          frame_d   = {HDR_PAT, link.din} << 1;
          dout_d    = HDR_PAT[HDR_W-1];
          doutVld_d = 1'b1;
        end
      end

      HDR: begin
        dout_d    = frame_q[FRM_W-1];
        doutVld_d = 1'b1;
        frame_d   = frame_q << 1;
        if (cnt_q == HDR_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d = '0;
          if (GAP_CYC > 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dout_d    = frame_q[FRM_W-1];
          doutVld_d = 1'b1;
          frame_d   = frame_q << 1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers. A reset aborts any frame in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      dout_q    <= 1'b0;
      doutVld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      dout_q    <= dout_d;
      doutVld_q <= doutVld_d;
    end
  end

  assign link.dout     = dout_q;
  assign link.dout_vld = doutVld_q;
  assign link.din_rdy  = (state_q == IDLE);
  assign link.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx with three configurations:
// u0 uses the defaults, u1 has no gap, and u2 has a 1-bit header and a 1-bit payload.
module tb_seq_frame_tx;

  logic clk = 1'b0;
  logic rst_n;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;

  logic       drvVld [3];
  logic [7:0] drvDin [3];
  logic [2:0] obsDout, obsVld, obsRdy, obsBusy;

  seq_frame_tx_if #(.DATA_W(8)) link0 ();
  seq_frame_tx_if #(.DATA_W(8)) link1 ();
  seq_frame_tx_if #(.DATA_W(1)) link2 ();

  seq_frame_tx u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link0)
  );

  seq_frame_tx #(.GAP_CYC(0)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link1)
  );

  seq_frame_tx #(.DATA_W(1), .HDR_W(1), .HDR_PAT(1'b1), .GAP_CYC(2)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link2)
  );

  assign link0.din_vld = drvVld[0];
  assign link0.din     = drvDin[0];
  assign link1.din_vld = drvVld[1];
  assign link1.din     = drvDin[1];
  assign link2.din_vld = drvVld[2];
  assign link2.din     = drvDin[2][0];

  assign obsDout = {link2.dout,     link1.dout,     link0.dout};
  assign obsVld  = {link2.dout_vld, link1.dout_vld, link0.dout_vld};
  assign obsRdy  = {link2.din_rdy,  link1.din_rdy,  link0.din_rdy};
  assign obsBusy = {link2.busy,     link1.busy,     link0.busy};

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkLink(input int d, input string tag, input logic expDout, input logic expVld,
                           input logic expRdy, input logic expBusy);
    checkOutput({tag, "_dout"}, 32'(obsDout[d]), 32'(expDout));
    checkOutput({tag, "_vld"},  32'(obsVld[d]),  32'(expVld));
    checkOutput({tag, "_rdy"},  32'(obsRdy[d]),  32'(expRdy));
    checkOutput({tag, "_busy"}, 32'(obsBusy[d]), 32'(expBusy));
  endtask

  // Send one word and check every cycle of its frame against the reference bit sequence.
  // On return the bench sits on the cycle in which din_rdy is high again.
  task automatic applyStimulus(input int d, input logic [7:0] w, input int hw, input int dw,
                               input int gap, input logic [7:0] hdrPat, input bit hold,
                               input string name, output int startCyc);
    logic expBit;
    drvDin[d] = w;
    drvVld[d] = 1'b1;
    tick();
    startCyc = cycleNum;
    for (int k = 0; k < hw + dw; k++) begin
      if (k < hw) expBit = hdrPat[hw-1-k];
      else        expBit = w[dw-1-(k-hw)];
      checkLink(d, $sformatf("%s_b%0d", name, k), expBit, 1'b1, 1'b0, 1'b1);
      drvVld[d] = hold;
      drvDin[d] = w ^ 8'h5A ^ 8'(k);
      tick();
    end
    for (int g = 0; g < gap; g++) begin
      checkLink(d, $sformatf("%s_gap%0d", name, g), 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    checkLink(d, $sformatf("%s_end", name), 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int s1, s2;
    bit hold;
    logic w;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drvVld[d] = 1'b0;
      drvDin[d] = 8'h00;
    end

    // Reset held with random inputs: every configuration must stay idle.
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 3; d++) begin
        drvVld[d] = 1'($urandom_range(0, 1));
        drvDin[d] = 8'($urandom_range(0, 255));
      end
      tick();
      for (int d = 0; d < 3; d++) checkLink(d, $sformatf("rst%0d_u%0d", i, d), 1'b0, 1'b0, 1'b1, 1'b0);
    end

    for (int d = 0; d < 3; d++) drvVld[d] = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkLink(0, $sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    end

    $display("[TB] single frame A5");
    applyStimulus(0, 8'hA5, 4, 8, 2, 8'h0B, 1'b0, "single", s1);

    $display("[TB] back-to-back FF then 00");
    applyStimulus(0, 8'hFF, 4, 8, 2, 8'h0B, 1'b1, "b2bA", s1);
    applyStimulus(0, 8'h00, 4, 8, 2, 8'h0B, 1'b0, "b2bB", s2);
    checkOutput("b2b_period", 32'(s2 - s1), 32'd15);

    $display("[TB] zero gap with 00 then 80");
    applyStimulus(1, 8'h00, 4, 8, 0, 8'h0B, 1'b1, "gap0A", s1);
    applyStimulus(1, 8'h80, 4, 8, 0, 8'h0B, 1'b0, "gap0B", s2);
    checkOutput("gap0_period", 32'(s2 - s1), 32'd13);

    $display("[TB] reset during payload of 3C");
    drvDin[0] = 8'h3C;
    drvVld[0] = 1'b1;
    tick();
    drvVld[0] = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checkLink(0, "mid_before", 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkLink(0, "mid_async", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkLink(0, $sformatf("mid_after%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(0, 8'hC3, 4, 8, 2, 8'h0B, 1'b0, "c3", s1);

    $display("[TB] 1-bit header/payload sweep");
    for (int i = 0; i < 1000; i++) begin
      w    = 1'($urandom_range(0, 1));
      hold = (i < 999) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(2, {7'b0, w}, 1, 1, 2, 8'h01, hold, $sformatf("sw%0d", i), s1);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
